// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Op encodings, FSM states and the default datapath width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MFHI = 2'b10,
    OP_MFLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT_RUN = 2'b01,
    DIV_RUN  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO register pair.
// Loaded from either the multiplier or the divider results.
module hilo_regs
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             sel_div,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Capture the selected unit's result on a write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= sel_div ? div_hi : mult_hi;
      lo <= sel_div ? div_lo : mult_lo;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the iterative
// multiplier/divider: start pulses, stall, HI/LO, errors.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             divZero,
  output logic             timeout,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic             mult_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
  logic [WIDTH-1:0] ua_nx, ub_nx, res_nx;
  logic             busy_nx, rv_nx, dz_nx;
  logic             to_nx, ms_nx, ds_nx;
  logic             we, sel_div, unit_done;

  assign cnt_inc = cnt + CW'(1);

  // A done raised during the start pulse cycle is too early.
  assign unit_done = (state == MULT_RUN) ? mult_done
                                         : div_done;

  // Next-state, counter and registered-output decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ua_nx    = unit_a;
    ub_nx    = unit_b;
    res_nx   = result;
    rv_nx    = 1'b0;
    dz_nx    = 1'b0;
    to_nx    = 1'b0;
    ms_nx    = 1'b0;
    ds_nx    = 1'b0;
    we       = 1'b0;
    sel_div  = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          unique case (op_e'(op))
            OP_MULT: begin
              state_nx = MULT_RUN;
              ms_nx    = 1'b1;
              ua_nx    = srcA;
              ub_nx    = srcB;
              cnt_nx   = '0;
            end
            OP_DIV: begin
              if (srcB == '0) begin
                dz_nx = 1'b1;
              end else begin
                state_nx = DIV_RUN;
                ds_nx    = 1'b1;
                ua_nx    = srcA;
                ub_nx    = srcB;
                cnt_nx   = '0;
              end
            end
            OP_MFHI: begin
              res_nx = hi;
              rv_nx  = 1'b1;
            end
            OP_MFLO: begin
              res_nx = lo;
              rv_nx  = 1'b1;
            end
          endcase
        end
      end
      MULT_RUN, DIV_RUN: begin
        cnt_nx = cnt_inc;
        if (unit_done && !(mult_start || div_start)) begin
          we       = 1'b1;
          sel_div  = (state == DIV_RUN);
          state_nx = IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          to_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      divZero      <= 1'b0;
      timeout      <= 1'b0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      unit_a       <= '0;
      unit_b       <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      busy         <= busy_nx;
      result       <= res_nx;
      result_valid <= rv_nx;
      divZero      <= dz_nx;
      timeout      <= to_nx;
      mult_start   <= ms_nx;
      div_start    <= ds_nx;
      unit_a       <= ua_nx;
      unit_b       <= ub_nx;
    end
  end

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .sel_div(sel_div),
    .mult_hi(mult_hi),
    .mult_lo(mult_lo),
    .div_hi (div_hi),
    .div_lo (div_lo),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table,
// corner sequences and a randomized reference-model run.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset, op_valid;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, result_valid, divZero, timeout;
  logic        mult_start, div_start;
  logic [31:0] result, unit_a, unit_b, hi, lo;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .srcA        (srcA),
    .srcB        (srcB),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .divZero     (divZero),
    .timeout     (timeout),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .mult_done   (mult_done),
    .div_done    (div_done),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    int          dly;
    logic [31:0] rhi, rlo;
    int          ms, ds;
    logic        dz, rv;
    logic [31:0] res, ehi, elo;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pulses();
    return {27'd0, mult_start, div_start,
            result_valid, divZero, timeout};
  endfunction

  // reference model (spec-level, plain ints)
  int          m_mode, m_age;
  logic [31:0] m_hi, m_lo, m_res, m_ua, m_ub;
  logic        m_ms, m_ds, m_rv, m_dz, m_to;

  task automatic model_step();
    logic d;
    m_ms = 0; m_ds = 0; m_rv = 0; m_dz = 0; m_to = 0;
    if (reset) begin
      m_mode = 0; m_age = 0;
      m_hi = 0; m_lo = 0; m_res = 0;
      m_ua = 0; m_ub = 0;
    end else if (m_mode == 0) begin
      if (op_valid) begin
        if (op == OP_MULT) begin
          m_mode = 1; m_age = 0; m_ms = 1;
          m_ua = srcA; m_ub = srcB;
        end else if (op == OP_DIV) begin
          if (srcB == 0) m_dz = 1;
          else begin
            m_mode = 2; m_age = 0; m_ds = 1;
            m_ua = srcA; m_ub = srcB;
          end
        end else begin
          m_res = (op == OP_MFHI) ? m_hi : m_lo;
          m_rv  = 1;
        end
      end
    end else begin
      d = (m_mode == 1) ? mult_done : div_done;
      if (d && m_age >= 1) begin
        m_hi = (m_mode == 1) ? mult_hi : div_hi;
        m_lo = (m_mode == 1) ? mult_lo : div_lo;
        m_mode = 0;
      end else if (m_age + 1 == TO) begin
        m_to = 1;
        m_mode = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    int nms, nds, nlow, nto;
    reset = 1; op_valid = 0; op = 0;
    srcA = 0; srcB = 0;
    mult_done = 0; div_done = 0;
    mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;

    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_pulses", pulses(), 0);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ua", unit_a, 0);
    chk("rst_ub", unit_b, 0);
    reset = 0;
    tick();

    tbl[0] = '{OP_MULT, 32'hFFFF_FFFF, 32'd2, 5,
               32'd1, 32'hFFFF_FFFE, 1, 0, 0, 0,
               0, 32'd1, 32'hFFFF_FFFE};
    tbl[1] = '{OP_MFHI, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'd1, 32'd1, 32'hFFFF_FFFE};
    tbl[2] = '{OP_MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE};
    tbl[3] = '{OP_DIV, 32'd100, 32'd7, 33,
               32'd2, 32'd14, 0, 1, 0, 0,
               0, 32'd2, 32'd14};
    tbl[4] = '{OP_MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'd14, 32'd2, 32'd14};
    tbl[5] = '{OP_DIV, 32'd55, 32'd0, 0, 0, 0,
               0, 0, 1, 0, 0, 32'd2, 32'd14};
    tbl[6] = '{OP_MFHI, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'd2, 32'd2, 32'd14};

    for (int i = 0; i < 7; i++) begin
      nms = 0; nds = 0; nlow = 0;
      op_valid = 1; op = tbl[i].op;
      srcA = tbl[i].a; srcB = tbl[i].b;
      tick();
      op_valid = 0;
      nms += int'(mult_start);
      nds += int'(div_start);
      chk($sformatf("v%0d_rv", i), result_valid,
          tbl[i].rv);
      chk($sformatf("v%0d_dz", i), divZero, tbl[i].dz);
      if (tbl[i].rv)
        chk($sformatf("v%0d_res", i), result,
            tbl[i].res);
      if (tbl[i].ms + tbl[i].ds > 0) begin
        chk($sformatf("v%0d_busy", i), busy, 1);
        chk($sformatf("v%0d_ua", i), unit_a, tbl[i].a);
        chk($sformatf("v%0d_ub", i), unit_b, tbl[i].b);
        for (int k = 0; k < tbl[i].dly; k++) begin
          tick();
          nms += int'(mult_start);
          nds += int'(div_start);
          if (!busy) nlow++;
        end
        mult_hi = tbl[i].rhi; mult_lo = tbl[i].rlo;
        div_hi  = tbl[i].rhi; div_lo  = tbl[i].rlo;
        if (tbl[i].ms > 0) mult_done = 1;
        else div_done = 1;
        tick();
        mult_done = 0; div_done = 0;
        nms += int'(mult_start);
        nds += int'(div_start);
        chk($sformatf("v%0d_busylow", i), nlow, 0);
      end
      chk($sformatf("v%0d_busyend", i), busy, 0);
      chk($sformatf("v%0d_nms", i), nms, tbl[i].ms);
      chk($sformatf("v%0d_nds", i), nds, tbl[i].ds);
      chk($sformatf("v%0d_hi", i), hi, tbl[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, tbl[i].elo);
    end

    // stray done in IDLE
    div_hi = 32'hBAD0; div_lo = 32'hBAD1; div_done = 1;
    tick();
    div_done = 0;
    chk("idle_done_hi", hi, 2);
    chk("idle_done_lo", lo, 14);

    // timeout with div_done withheld
    op_valid = 1; op = OP_DIV; srcA = 5; srcB = 3;
    tick();
    op_valid = 0;
    chk("to_dstart", div_start, 1);
    nto = 0; nlow = 0;
    repeat (TO - 1) begin
      tick();
      nto += int'(timeout);
      if (!busy) nlow++;
    end
    chk("to_early", nto, 0);
    chk("to_busylow", nlow, 0);
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_hi", hi, 2);
    chk("to_lo", lo, 14);
    op_valid = 1; op = OP_MULT; srcA = 3; srcB = 4;
    tick();
    op_valid = 0;
    chk("to_once", timeout, 0);
    chk("to_next_ms", mult_start, 1);
    tick();
    mult_hi = 0; mult_lo = 12; mult_done = 1;
    tick();
    mult_done = 0;
    chk("to_next_hi", hi, 0);
    chk("to_next_lo", lo, 12);

    // done on the same edge the counter hits TIMEOUT
    op_valid = 1; op = OP_DIV; srcA = 9; srcB = 2;
    tick();
    op_valid = 0;
    repeat (TO - 1) tick();
    div_hi = 1; div_lo = 4; div_done = 1;
    tick();
    div_done = 0;
    chk("race_to", timeout, 0);
    chk("race_hi", hi, 1);
    chk("race_lo", lo, 4);
    chk("race_busy", busy, 0);

    // done during the start-pulse cycle is too early
    op_valid = 1; op = OP_DIV; srcA = 21; srcB = 4;
    div_hi = 1; div_lo = 5; div_done = 1;
    tick();
    op_valid = 0;
    tick();
    div_done = 0;
    chk("early_busy", busy, 1);
    chk("early_hi", hi, 1);
    chk("early_lo", lo, 4);
    div_done = 1;
    tick();
    div_done = 0;
    chk("early_lo2", lo, 5);

    // other unit's done and requests ignored while busy
    op_valid = 1; op = OP_DIV; srcA = 50; srcB = 5;
    tick();
    op = OP_MULT; srcA = 7; srcB = 8;
    mult_hi = 32'hDEAD; mult_lo = 32'hBEEF;
    nms = 0; nlow = 0;
    for (int k = 0; k < 6; k++) begin
      mult_done = k[0];
      tick();
      nms += int'(mult_start);
      if (!busy) nlow++;
    end
    op_valid = 0; mult_done = 0;
    chk("ign_ms", nms, 0);
    chk("ign_busy", nlow, 0);
    chk("ign_ua", unit_a, 50);
    div_hi = 0; div_lo = 10; div_done = 1;
    tick();
    div_done = 0;
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 10);

    // reset mid MULT_RUN then stale done
    op_valid = 1; op = OP_MULT; srcA = 6; srcB = 6;
    tick();
    op_valid = 0;
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("mr_busy", busy, 0);
    chk("mr_pulses", pulses(), 0);
    chk("mr_hi", hi, 0);
    chk("mr_lo", lo, 0);
    chk("mr_ua", unit_a, 0);
    mult_hi = 9; mult_lo = 9; mult_done = 1;
    tick();
    mult_done = 0;
    chk("mr_stale_hi", hi, 0);
    chk("mr_stale_lo", lo, 0);
    chk("mr_stale_busy", busy, 0);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 399) == 0);
      op_valid = ($urandom_range(0, 2) != 0);
      op = 2'($urandom_range(0, 3));
      srcA = $urandom;
      srcB = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      mult_done = ($urandom_range(0, 15) == 0);
      div_done  = ($urandom_range(0, 15) == 0);
      mult_hi = $urandom; mult_lo = $urandom;
      div_hi  = $urandom; div_lo  = $urandom;
      model_step();
      tick();
      chk("rnd_busy", busy, m_mode != 0);
      chk("rnd_pulses", pulses(),
          {27'd0, m_ms, m_ds, m_rv, m_dz, m_to});
      chk("rnd_result", result, m_res);
      chk("rnd_hi", hi, m_hi);
      chk("rnd_lo", lo, m_lo);
      chk("rnd_ua", unit_a, m_ua);
      chk("rnd_ub", unit_b, m_ub);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer that sits between the CPU control unit and the iterative multiplier/divider datapaths.
- Accepts MULT/DIV/MFHI/MFLO requests and issues one-cycle start pulses to the selected unit.
- Stalls the CPU while a unit runs, owns the architectural HI/LO registers, and flags divide-by-zero and unit timeouts.
- Each unit runs one operation at a time; the controller serialises them.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 40, max cycles to wait for a unit's done before aborting.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request strobe from control unit; sampled only when busy=0.
- op  in  2  00 MULT, 01 DIV, 10 MFHI, 11 MFLO.
- srcA  in  WIDTH  operand A / dividend.
- srcB  in  WIDTH  operand B / divisor.
- busy  out  1  stall request; high while a unit is running.
- result  out  WIDTH  MFHI/MFLO read data.
- result_valid  out  1  one-cycle pulse; result is valid.
- divZero  out  1  one-cycle pulse; DIV with srcB=0 was rejected.
- timeout  out  1  one-cycle pulse; unit did not finish in TIMEOUT cycles.
- mult_start, div_start  out  1  one-cycle start pulses.
- unit_a, unit_b  out  WIDTH  latched operands, shared by both units.
- mult_done, div_done  in  1  completion pulses from the units.
- mult_hi, mult_lo, div_hi, div_lo  in  WIDTH  unit results (div_hi = remainder, div_lo = quotient).
- hi, lo  out  WIDTH  architectural HI/LO registers.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; hi, lo, result, unit_a, unit_b = 0; busy, result_valid, divZero, timeout, mult_start, div_start = 0; cycle counter = 0.
- States: IDLE, MULT_RUN, DIV_RUN. busy = (state != IDLE).
- IDLE, op_valid=1, acceptance edge (cycle N):
  - MULT: latch srcA/srcB into unit_a/unit_b; go to MULT_RUN. In cycle N+1, mult_start=1 for exactly one cycle and busy=1.
  - DIV, srcB != 0: same as MULT via DIV_RUN and div_start.
  - DIV, srcB = 0: no start pulse; divZero=1 in cycle N+1 only; stay IDLE; hi/lo unchanged.
  - MFHI/MFLO: result = hi/lo; result_valid=1 in cycle N+1; stay IDLE.
- op_valid with busy=1 is ignored; no queuing.
- MULT_RUN/DIV_RUN:
  - Counter clears on entry and increments every cycle.
  - The matching done is honoured only from the cycle after the start pulse. On that edge, latch hi/lo from the unit and return to IDLE. busy falls the next cycle, so the first new request is accepted the cycle busy reads 0.
  - The other unit's done is ignored.
  - done arriving in IDLE is ignored.
- Timeout: if the counter reaches TIMEOUT without done, return to IDLE, timeout=1 for one cycle, hi/lo unchanged.
- Done on the same edge the counter hits TIMEOUT: done wins, no timeout pulse.
- Reset mid-operation: immediate return to IDLE with the reset values above. A stale done after reset is ignored because state is IDLE.
- MFHI/MFLO back-to-back with a just-completed op returns the new hi/lo, since the latch precedes the next acceptance.
- Counter width is clog2(TIMEOUT+1). Wrap is impossible because the timeout exits first.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT/OP_DIV/OP_MFHI/OP_MFLO.
  - state enum.
  - WIDTH default.
- One natural sub-module: hilo_regs, holding the HI/LO register pair with a write enable and 2:1 source select (mult vs div). The FSM and counter stay in muldiv_ctrl.

Test Plan:
- DIV srcA=100, srcB=7; div_done 33 cycles after start with div_hi=2, div_lo=14 -> one div_start pulse; busy high until done; hi=2, lo=14; MFLO then gives result=14 with result_valid one cycle.
- MULT srcA=0xFFFF_FFFF, srcB=2; mult_done with hi=1, lo=0xFFFF_FFFE -> hi/lo latched; div_start never asserted.
- DIV srcB=0 -> divZero pulse one cycle after acceptance; no start pulse; busy stays 0; hi/lo keep their prior values.
- DIV with div_done withheld, TIMEOUT=40 -> timeout pulse 40 cycles after entering DIV_RUN; back in IDLE; hi/lo unchanged; a following MULT is accepted.
- op_valid held high during DIV_RUN with op=MULT, plus a stray mult_done -> both ignored; only div_done completes the op.
- reset asserted 5 cycles into MULT_RUN, then mult_done pulsed -> all outputs at reset values; hi/lo stay 0.
